// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared types and helpers for the register write arbiter.
// FSM state encoding, hold counter width and index width function.
package reg_arb_pkg;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam int HOLD_W = 4;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker; first set req_val at or
// above ptr, wrapping. Ports: req_val, ptr in; any, idx out.
module rr_pick
  import reg_arb_pkg::*;
#(
  parameter int p_nreqs = 4
) (
  input  logic [p_nreqs-1:0]         req_val,
  input  logic [idx_w(p_nreqs)-1:0]  ptr,
  output logic                       any,
  output logic [idx_w(p_nreqs)-1:0]  idx
);

  localparam int IW = idx_w(p_nreqs);

  logic found;

  assign any = |req_val;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < p_nreqs; k++) begin
      int j;
      j = (int'(ptr) + k) % p_nreqs;
      if (!found && req_val[j]) begin
        idx   = IW'(j);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin val/rdy writers onto one shared register
// with bounded burst lock. Ports: clk, reset, req_*, q, q_owner, q_upd.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int p_nbits    = 32,
  parameter int p_nreqs    = 4,
  parameter int p_max_hold = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [p_nreqs-1:0]         req_val,
  output logic [p_nreqs-1:0]         req_rdy,
  input  logic [p_nreqs-1:0]         req_lock,
  input  logic [p_nreqs*p_nbits-1:0] req_msg,
  output logic [p_nbits-1:0]         q,
  output logic [idx_w(p_nreqs)-1:0]  q_owner,
  output logic                       q_upd
);

  localparam int IW = idx_w(p_nreqs);

  logic [0:0]        state;
  logic [IW-1:0]     gnt;
  logic [IW-1:0]     ptr;
  logic [HOLD_W-1:0] hold;

  logic          any;
  logic [IW-1:0] pick;
  logic          fire;
  logic          stay;
  logic [IW-1:0] nxt;

  rr_pick #(
    .p_nreqs (p_nreqs)
  ) u_pick (
    .req_val (req_val),
    .ptr     (ptr),
    .any     (any),
    .idx     (pick)
  );

  // Ready is decoded from registered state only, never from req_val.
  always_comb begin
    req_rdy = '0;
    if (state == GRANT)
      req_rdy[gnt] = 1'b1;
  end

  assign fire = (state == GRANT) && req_val[gnt];

  assign stay = req_lock[gnt] &&
    (({1'b0, hold} + 5'd1) < 5'(p_max_hold));

  assign nxt = (gnt == IW'(p_nreqs - 1)) ?
    '0 : gnt + IW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gnt     <= '0;
      ptr     <= '0;
      hold    <= '0;
      q       <= '0;
      q_owner <= '0;
      q_upd   <= 1'b0;
    end else begin
      q_upd <= fire;
      unique case (state)
        IDLE: begin
          if (any) begin
            state <= GRANT;
            gnt   <= pick;
            hold  <= '0;
          end
        end
        GRANT: begin
          if (fire) begin
            q       <= req_msg[gnt*p_nbits +: p_nbits];
            q_owner <= gnt;
            hold    <= hold + HOLD_W'(1);
            if (!stay) begin
              state <= IDLE;
              ptr   <= nxt;
            end
          end else begin
            state <= IDLE;
            ptr   <= nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
